// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared CPU types: memory op, d_cache requester state and error codes
package nand_cpu_pkg;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } MEM_OP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } DREQ_STATE;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISALIGN = 2'd2
    } DREQ_ERR;

endpackage

// File: rtl/d_cache_input_ifc.sv
// rtl/d_cache_input_ifc.sv - request bundle from the memory stage to the d_cache
interface d_cache_input_ifc;
    import nand_cpu_pkg::*;

    logic        mem_access;
    logic [15:0] address;
    MEM_OP       mem_op;
    logic [15:0] data;

    modport out (output mem_access, address, mem_op, data);
    modport in  (input  mem_access, address, mem_op, data);
endinterface

// File: rtl/d_cache_output_ifc.sv
// rtl/d_cache_output_ifc.sv - response bundle from the d_cache back to the memory stage
interface d_cache_output_ifc;
    logic        valid;
    logic [15:0] data;

    modport out (output valid, data);
    modport in  (input  valid, data);
endinterface

// File: rtl/d_cache_requester.sv
// rtl/d_cache_requester.sv - memory-stage initiator holding one d_cache request until it is answered
module d_cache_requester
    import nand_cpu_pkg::*;
#(
    parameter int TIMEOUT     = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 ex_valid,
    input  logic                 ex_mem_access,
    input  MEM_OP                ex_mem_op,
    input  logic [15:0]          ex_address,
    input  logic [15:0]          ex_data,
    input  logic                 flush,
    output logic                 stall,
    output logic                 dc_valid_o,
    d_cache_input_ifc.out        dc_req,
    d_cache_output_ifc.in        dc_rsp,
    output logic                 wb_valid,
    output logic [15:0]          wb_data,
    output logic                 err,
    output logic [1:0]           err_code
);

    // Wide enough to hold TIMEOUT itself; the ERR exit is taken at TIMEOUT-1 so it never wraps.
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    DREQ_STATE      state, state_n;
    MEM_OP          req_op, req_op_n;
    logic [15:0]    req_addr, req_addr_n;
    logic [15:0]    req_data, req_data_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           flushed, flushed_n;
    logic [15:0]    wb_data_q, wb_data_n;
    DREQ_ERR        err_code_q, err_code_n;
    logic           start;
    logic           req_active;

    // Request fields always come from the latched registers so they stay stable while BUSY.
    assign dc_req.mem_access = req_active;
    assign dc_req.address    = req_addr;
    assign dc_req.mem_op     = req_op;
    assign dc_req.data       = req_data;

    assign wb_data  = wb_data_q;
    assign err      = (state == ERR);
    assign err_code = err_code_q;

    // Next-state and output decode for the IDLE -> BUSY -> DONE -> IDLE handshake.
    always_comb begin
        state_n    = state;
        req_op_n   = req_op;
        req_addr_n = req_addr;
        req_data_n = req_data;
        cnt_n      = cnt;
        flushed_n  = flushed;
        wb_data_n  = wb_data_q;
        err_code_n = err_code_q;
        stall      = 1'b0;
        dc_valid_o = 1'b0;
        req_active = 1'b0;
        wb_valid   = 1'b0;
        start      = ex_valid & ex_mem_access & ~flush;

        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    if (ALIGN_CHECK && ex_address[0]) begin
                        state_n    = ERR;
                        err_code_n = ERR_MISALIGN;
                    end else begin
                        req_op_n   = ex_mem_op;
                        req_addr_n = ex_address;
                        req_data_n = ex_data;
                        cnt_n      = '0;
                        state_n    = BUSY;
                    end
                end
            end
            BUSY: begin
                stall      = 1'b1;
                dc_valid_o = 1'b1;
                req_active = 1'b1;
                cnt_n      = cnt + 1'b1;
                // A squashed transaction still runs to completion so a store is never torn.
                if (flush) begin
                    flushed_n = 1'b1;
                end
                if (dc_rsp.valid) begin
                    wb_data_n = (req_op == MEM_LOAD) ? dc_rsp.data : 16'h0000;
                    state_n   = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_n    = ERR;
                    err_code_n = ERR_TIMEOUT;
                end
            end
            DONE: begin
                wb_valid  = ~flushed;
                flushed_n = 1'b0;
                state_n   = IDLE;
            end
            ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and request/result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            req_op     <= MEM_LOAD;
            req_addr   <= 16'h0000;
            req_data   <= 16'h0000;
            cnt        <= '0;
            flushed    <= 1'b0;
            wb_data_q  <= 16'h0000;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_n;
            req_op     <= req_op_n;
            req_addr   <= req_addr_n;
            req_data   <= req_data_n;
            cnt        <= cnt_n;
            flushed    <= flushed_n;
            wb_data_q  <= wb_data_n;
            err_code_q <= err_code_n;
        end
    end

endmodule

// File: tb/tb_d_cache_requester.sv
// tb/tb_d_cache_requester.sv - scoreboard bench for d_cache_requester
module tb_d_cache_requester;
    import nand_cpu_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_access = 1'b0;
    MEM_OP       ex_mem_op = MEM_LOAD;
    logic [15:0] ex_address = 16'h0000;
    logic [15:0] ex_data = 16'h0000;
    logic        flush = 1'b0;
    logic        stall;
    logic        dc_valid_o;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    d_cache_input_ifc  dc_req_if ();
    d_cache_output_ifc dc_rsp_if ();

    typedef struct {
        logic [15:0] data;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    d_cache_requester #(
        .TIMEOUT     (TO),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .ex_valid      (ex_valid),
        .ex_mem_access (ex_mem_access),
        .ex_mem_op     (ex_mem_op),
        .ex_address    (ex_address),
        .ex_data       (ex_data),
        .flush         (flush),
        .stall         (stall),
        .dc_valid_o    (dc_valid_o),
        .dc_req        (dc_req_if),
        .dc_rsp        (dc_rsp_if),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every writeback pulse must match the oldest expected result, data and cycle.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: wb_valid=1 wb_data=%h at cycle %0d, required no result", wb_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_data !== mon_e.data || cyc != mon_e.cycle) begin
                    errors++;
                    $display("FAIL wb_result: wb_data=%h cycle=%0d, required wb_data=%h cycle=%0d",
                             wb_data, cyc, mon_e.data, mon_e.cycle);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input MEM_OP op, input logic [15:0] a, input logic [15:0] d);
        ex_valid      = 1'b1;
        ex_mem_access = 1'b1;
        ex_mem_op     = op;
        ex_address    = a;
        ex_data       = d;
    endtask

    task automatic idle_in();
        ex_valid      = 1'b0;
        ex_mem_access = 1'b0;
    endtask

    // One full transaction: accept, nwait BUSY cycles without valid, then a valid cycle, then DONE.
    task automatic do_txn(input string tag, input MEM_OP op, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] rd, input int nwait);
        exp_t e;
        @(negedge clk);
        issue(op, a, wd);
        e.data  = (op == MEM_LOAD) ? rd : 16'h0000;
        e.cycle = cyc + 2 + nwait;
        exp_q.push_back(e);
        #1 chk1({tag, "_stall_accept"}, stall, 1'b1);
        for (int i = 0; i <= nwait; i++) begin
            @(negedge clk);
            idle_in();
            dc_rsp_if.valid = (i == nwait);
            dc_rsp_if.data  = rd;
            #1;
            chk1 ({tag, "_dc_valid"}, dc_valid_o, 1'b1);
            chk1 ({tag, "_mem_access"}, dc_req_if.mem_access, 1'b1);
            chk16({tag, "_addr"}, dc_req_if.address, a);
            chk16({tag, "_data"}, dc_req_if.data, wd);
            chk1 ({tag, "_op"}, dc_req_if.mem_op, op);
            chk1 ({tag, "_stall_busy"}, stall, 1'b1);
        end
        @(negedge clk);
        dc_rsp_if.valid = 1'b0;
        #1;
        chk1({tag, "_stall_done"}, stall, 1'b0);
        chk1({tag, "_dc_valid_done"}, dc_valid_o, 1'b0);
    endtask

    initial begin
        dc_rsp_if.valid = 1'b0;
        dc_rsp_if.data  = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1 ("rst_stall", stall, 1'b0);
        chk1 ("rst_dc_valid", dc_valid_o, 1'b0);
        chk1 ("rst_mem_access", dc_req_if.mem_access, 1'b0);
        chk16("rst_addr", dc_req_if.address, 16'h0000);
        chk16("rst_data", dc_req_if.data, 16'h0000);
        chk1 ("rst_wb_valid", wb_valid, 1'b0);
        chk16("rst_wb_data", wb_data, 16'h0000);
        chk1 ("rst_err", err, 1'b0);
        chk16("rst_err_code", {14'd0, err_code}, 16'd0);
        n_rst = 1'b1;

        // Load hit: wb_valid two cycles after accept
        do_txn("load_hit", MEM_LOAD, 16'h0010, 16'h0000, 16'hBEEF, 0);

        // Store answered on the 5th BUSY cycle; wb_data forced to zero
        do_txn("store", MEM_STORE, 16'h0020, 16'h1234, 16'hFFFF, 4);

        // Flush during BUSY: completes but no writeback
        @(negedge clk);
        issue(MEM_LOAD, 16'h0030, 16'h0000);
        @(negedge clk);
        idle_in();
        flush = 1'b1;
        #1 chk1("flush_dc_valid", dc_valid_o, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        dc_rsp_if.valid = 1'b1;
        dc_rsp_if.data  = 16'h5555;
        #1 chk16("flush_addr_held", dc_req_if.address, 16'h0030);
        @(negedge clk);
        dc_rsp_if.valid = 1'b0;
        #1;
        chk1("flush_wb_valid", wb_valid, 1'b0);
        chk1("flush_stall_done", stall, 1'b0);
        do_txn("after_flush", MEM_LOAD, 16'h0040, 16'h0000, 16'h0A0A, 0);

        // Non-memory and flushed instructions are ignored; stray response in IDLE ignored
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_access = 1'b0;
        dc_rsp_if.valid = 1'b1;
        #1 chk1("nonmem_stall", stall, 1'b0);
        @(negedge clk);
        ex_mem_access = 1'b1;
        flush = 1'b1;
        #1 chk1("flushed_stall", stall, 1'b0);
        @(negedge clk);
        idle_in();
        flush = 1'b0;
        dc_rsp_if.valid = 1'b0;
        #1 chk1("flushed_no_req", dc_valid_o, 1'b0);

        // Response on the last allowed BUSY cycle beats the timeout
        do_txn("edge_to", MEM_LOAD, 16'h0080, 16'h0000, 16'hC0DE, TO - 1);
        #1 chk1("edge_to_no_err", err, 1'b0);

        // Reset mid-BUSY drops the request
        @(negedge clk);
        issue(MEM_LOAD, 16'h0050, 16'h0000);
        @(negedge clk);
        idle_in();
        #1 chk1("midrst_busy", dc_valid_o, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        #1;
        chk1 ("midrst_dc_valid", dc_valid_o, 1'b0);
        chk1 ("midrst_mem_access", dc_req_if.mem_access, 1'b0);
        chk16("midrst_addr", dc_req_if.address, 16'h0000);
        chk1 ("midrst_stall", stall, 1'b0);
        chk16("midrst_wb_data", wb_data, 16'h0000);
        n_rst = 1'b1;
        do_txn("after_rst", MEM_LOAD, 16'h0060, 16'h0000, 16'h7777, 2);

        // Misaligned word access
        @(negedge clk);
        issue(MEM_LOAD, 16'h0011, 16'h0000);
        #1 chk1("mis_stall_accept", stall, 1'b1);
        @(negedge clk);
        idle_in();
        #1;
        chk1 ("mis_err", err, 1'b1);
        chk16("mis_err_code", {14'd0, err_code}, 16'd2);
        chk1 ("mis_dc_valid", dc_valid_o, 1'b0);
        chk1 ("mis_stall", stall, 1'b1);
        @(negedge clk);
        #1 chk1("mis_err_sticky", err, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk1 ("mis_rst_err", err, 1'b0);
        chk16("mis_rst_err_code", {14'd0, err_code}, 16'd0);

        // Timeout after TO BUSY cycles without a response
        @(negedge clk);
        issue(MEM_LOAD, 16'h0070, 16'h0000);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            idle_in();
            #1;
            chk1("to_dc_valid", dc_valid_o, 1'b1);
            chk1("to_no_err_yet", err, 1'b0);
        end
        @(negedge clk);
        #1;
        chk1 ("to_err", err, 1'b1);
        chk16("to_err_code", {14'd0, err_code}, 16'd1);
        chk1 ("to_stall", stall, 1'b1);
        chk1 ("to_dc_valid_off", dc_valid_o, 1'b0);
        @(negedge clk);
        dc_rsp_if.valid = 1'b1;
        dc_rsp_if.data  = 16'h9999;
        #1 chk1("to_err_held", err, 1'b1);
        @(negedge clk);
        dc_rsp_if.valid = 1'b0;
        #1;
        chk1("to_err_held2", err, 1'b1);
        chk1("to_stall_held", stall, 1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
